multi_line_delay: RTL and testbench
===================================

# multi_line_delay

Parametrised multi-tap line delay for the neuro_skin video pipeline. It accepts one pixel per `ce` cycle and presents the current pixel together with the same column from up to `LINES` previous image lines, for building vertical context windows (3x3, 5x5, …) for downstream filters. Line length is set at run time. Every tap carries a validity flag, and taps are zeroed until their line has filled. Storage is `LINES` inferred single-port RAMs, each `2**ADDR_W` x `WIDTH`, sharing one column counter.

## Interface
- `WIDTH`, 16: pixel width in bits.
- `ADDR_W`, 10: RAM address width; the maximum line length is `2**ADDR_W`.
- `LINES`, 2: number of line delays. Output taps are 0..`LINES`.

- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-low reset. It is effective on any edge where `rst`=0, regardless of `ce`.
- `ce`  in  1: sample enable. One pixel is accepted per edge with `ce`=1.
- `din`  in  `WIDTH`: input pixel.
- `h_size`  in  `ADDR_W+1`: line length in pixels. Legal range is 2..`2**ADDR_W`.
- `taps`  out  `(LINES+1)*WIDTH`: tap k occupies bits `[k*WIDTH +: WIDTH]`. Tap 0 is the newest pixel.
- `tap_valid`  out  `LINES+1`: bit k=1 when tap k holds real data.
- `col`  out  `ADDR_W`: column index of the pixel currently on tap 0.
- `line_end`  out  1: 1 while tap 0 holds the last pixel of a line (`col`==`h_len`-1).

## Operation
- Let x(n) be the n-th pixel accepted since reset, counting from 0.
- After the edge that accepts x(n):
  - tap k = x(n − k·`h_len`) when n ≥ k·`h_len`; otherwise tap k = 0.
  - `tap_valid[k]` = (n ≥ k·`h_len`).
- `h_len` is an internal register. It loads `h_size` on reset and at every line wrap, i.e. on the edge accepting the pixel at `col`==`h_len`-1. A change to `h_size` in mid-line takes effect from the next line start.
- Column pointer `ptr`:
  - runs 0..`h_len`-1, then wraps to 0;
  - advances only on accepted pixels;
  - `col` is the registered value of `ptr` for the pixel on tap 0.
- RAM k (k=0..`LINES`-1):
  - operates read-before-write;
  - reads its stored value at the column and writes the value arriving from stage k;
  - each stage's write path may be skewed one cycle after its read (delayed address and data register) to close the chain;
  - the skew must be invisible at the outputs: all taps for sample n update on the same edge.
- Fill counter:
  - counts accepted pixels;
  - saturates at `LINES`·`h_len`;
  - drives `tap_valid`;
  - `tap_valid[0]` is 1 from the first accepted pixel.
- Taps whose `tap_valid` bit is 0 output 0. RAM contents are never cleared; this gating is the only mechanism that guarantees clean start-up.
- `ce`=0: no state change, all outputs hold.
- Reset, including mid-frame:
  - `ptr`, `col` and the fill counter go to 0;
  - `taps` = 0, `tap_valid` = 0, `line_end` = 0;
  - `h_len` reloads from `h_size`.
- If `h_size` is changed before a frame and followed by a reset, no stale data is shown. If it is changed without a reset, the taps are undefined for one line; `tap_valid` is not cleared in that case.
- An `h_size` value outside 2..`2**ADDR_W` is illegal, and behaviour is unspecified. Simulation asserts on it.

## Timing
- Latency from `din` to tap 0 is one edge: registered, not combinational.
- Line taps update on the same edge as tap 0. The outputs carry no extra pipeline latency.
- `line_end` and `col` are aligned with tap 0.
- Throughput is one pixel per clock with `ce` tied to 1, and arbitrary `ce` gaps are allowed.
- Back-to-back wraps at `h_len`=2 must work: the skewed write-after-read must not collide with the next read of the same address.
- With the first accepted pixel at edge 0 and `ce`=1 continuously, `tap_valid[k]` rises on edge k·`h_len`.

## Test plan
- **Basic ramp.** WIDTH=16, LINES=2, h_size=8, `ce`=1, din=0,1,2,…
  - tap0=n, tap1=n−8, tap2=n−16;
  - tap_valid = 001, then 011 at n=8, then 111 at n=16;
  - line_end high at n=7,15,23.
- **ce gaps.** Same ramp with `ce` toggling 1,0,0,1,… Taps advance only on accepted pixels; the values match the basic-ramp case sample-for-sample, and outputs hold during gaps.
- **Minimum line.** h_size=2, LINES=3, ramp.
  - tap3=n−6 from n=6;
  - col toggles 0,1;
  - no corruption from back-to-back address reuse.
- **Maximum line.** h_size=1024, ADDR_W=10, LINES=2, ramp. tap2=n−2048, and col wraps 1023→0.
- **Mid-line h_size change.** With h_size=8, change h_size to 4 at col=3. The current line still ends at col=7, and the following lines are 4 long (line_end every 4 pixels).
- **Reset mid-frame.** Drive `rst`=0 at n=20, with `ce` both 1 and 0 on that edge.
  - Next cycle: taps=0, tap_valid=0, col=0, line_end=0.
  - After release, the ramp restarted at 100 yields tap1=0 until 8 pixels are accepted, then tap1=100.

Source files
------------

// File: rtl/multi_line_delay.sv
// Multi-tap line delay: tap k presents the pixel k lines back in the same column, gated to 0 until filled.
// One-edge latency from din to every tap; ce=0 freezes all state (no backpressure beyond ce).
module multi_line_delay #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10,
  parameter int LINES  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [WIDTH-1:0]           din,
  input  logic [ADDR_W:0]            h_size,
  output logic [(LINES+1)*WIDTH-1:0] taps,
  output logic [LINES:0]             tap_valid,
  output logic [ADDR_W-1:0]          col,
  output logic                       line_end
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int FW    = ADDR_W + $clog2(LINES+1) + 1;

  logic [ADDR_W:0]          h_len;
  logic [ADDR_W-1:0]        ptr;
  logic [FW-1:0]            fill;
  logic                     started;
  logic                     wr_en;
  logic [WIDTH-1:0]         din_q;
  logic [LINES:0][WIDTH-1:0] stage;
  logic                     wrap;
  logic [FW-1:0]            fill_max;

  assign wrap     = ({1'b0, ptr} == (h_len - (ADDR_W+1)'(1)));
  assign fill_max = FW'(LINES) * FW'(h_len);
  assign stage[0] = din_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      col      <= '0;
      h_len    <= h_size;
      fill     <= '0;
      started  <= 1'b0;
      line_end <= 1'b0;
      wr_en    <= 1'b0;
      din_q    <= '0;
    end else if (ce) begin
      din_q    <= din;
      col      <= ptr;
      line_end <= wrap;
      wr_en    <= 1'b1;
      if (wrap) begin
        ptr   <= '0;
        h_len <= h_size;
      end else begin
        ptr <= ptr + ADDR_W'(1);
      end
      // fill holds the index of the pixel on tap 0, clamped at LINES*h_len
      if (!started)
        started <= 1'b1;
      else if (fill < fill_max)
        fill <= fill + FW'(1);
    end
  end

  // Each RAM is read at the incoming column while the previous sample is written
  // at its own (always different) column one accepted edge later.
  for (genvar k = 0; k < LINES; k++) begin : g_line
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (ce) begin
        rd_q <= mem[ptr];
        if (wr_en)
          mem[col] <= stage[k];
      end
    end

    assign stage[k+1] = rd_q;
  end

  always_comb begin
    tap_valid    = '0;
    tap_valid[0] = started;
    for (int k = 1; k <= LINES; k++)
      tap_valid[k] = started && (fill >= FW'(k) * FW'(h_len));
  end

  always_comb begin
    taps = '0;
    for (int k = 0; k <= LINES; k++)
      taps[k*WIDTH +: WIDTH] = tap_valid[k] ? stage[k] : '0;
  end

  h_size_legal: assert property (@(posedge clk)
    (h_size >= (ADDR_W+1)'(2)) && (h_size <= (ADDR_W+1)'(DEPTH)));

endmodule

// File: tb/tb_multi_line_delay.sv
// Scoreboard bench for multi_line_delay: stimulus pushes expected outputs, a monitor pops and compares.
module tb_multi_line_delay;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 10;
  localparam int LINES  = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       ce;
  logic [WIDTH-1:0]           din;
  logic [ADDR_W:0]            h_size;
  logic [(LINES+1)*WIDTH-1:0] taps;
  logic [LINES:0]             tap_valid;
  logic [ADDR_W-1:0]          col;
  logic                       line_end;

  multi_line_delay #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LINES(LINES)) dut (
    .clk(clk), .rst(rst), .ce(ce), .din(din), .h_size(h_size),
    .taps(taps), .tap_valid(tap_valid), .col(col), .line_end(line_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [(LINES+1)*WIDTH-1:0] taps;
    logic [LINES:0]             valid;
    logic [ADDR_W-1:0]          col;
    logic                       line_end;
    bit                         chk_lines;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: pixel history since reset plus line bookkeeping.
  int hist[$];
  int m_n, m_hl, m_len, m_next_col, m_cur_col;
  bit m_cur_le, chk_lines;

  function automatic exp_t build();
    exp_t e;
    e.taps = '0;
    e.valid = '0;
    e.col = ADDR_W'(m_cur_col);
    e.line_end = m_cur_le;
    e.chk_lines = chk_lines;
    if (m_n >= 0) begin
      for (int k = 0; k <= LINES; k++) begin
        int idx;
        idx = m_n - k * m_hl;
        if (idx >= 0) begin
          e.valid[k] = 1'b1;
          e.taps[k*WIDTH +: WIDTH] = WIDTH'(hist[idx]);
        end
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_n = -1;
    m_cur_col = 0;
    m_cur_le = 1'b0;
    m_next_col = 0;
    m_len = int'(h_size);
    m_hl = int'(h_size);
    chk_lines = 1'b1;
  endtask

  task automatic model_accept(input int d);
    hist.push_back(d);
    m_n++;
    m_cur_col = m_next_col;
    m_cur_le = (m_cur_col == m_len - 1);
    if (m_cur_le) begin
      m_next_col = 0;
      m_len = int'(h_size);
    end else begin
      m_next_col++;
    end
  endtask

  task automatic do_edge(input bit c, input bit r, input int d);
    rst = r;
    ce  = c;
    din = WIDTH'(d);
    @(posedge clk);
    if (!r)
      model_reset();
    else if (c)
      model_accept(d);
    sb.push_back(build());
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("tap0", 64'(taps[0 +: WIDTH]), 64'(e.taps[0 +: WIDTH]));
        chk("col", 64'(col), 64'(e.col));
        chk("line_end", 64'(line_end), 64'(e.line_end));
        if (e.chk_lines) begin
          chk("tap_valid", 64'(tap_valid), 64'(e.valid));
          for (int k = 1; k <= LINES; k++)
            chk($sformatf("tap%0d", k), 64'(taps[k*WIDTH +: WIDTH]), 64'(e.taps[k*WIDTH +: WIDTH]));
        end
      end
    end
  end

  initial begin
    int v;
    rst = 1'b0;
    ce = 1'b0;
    din = '0;
    h_size = 11'd8;
    chk_lines = 1'b1;

    // reset state, with ce low and high
    do_edge(0, 0, 0);
    do_edge(1, 0, 5);

    // basic ramp, h_size=8
    for (int i = 0; i < 30; i++) do_edge(1, 1, i);

    // ce gaps: accept on every third edge, garbage din while idle
    do_edge(0, 0, 0);
    v = 0;
    for (int c = 0; c < 90; c++) begin
      if (c % 3 == 0) do_edge(1, 1, v++);
      else            do_edge(0, 1, 16'hdead);
    end

    // mid-frame reset with ce=1, then ramp restarted at 100
    do_edge(0, 0, 0);
    for (int i = 0; i < 20; i++) do_edge(1, 1, i);
    do_edge(1, 0, 77);
    for (int i = 100; i < 130; i++) do_edge(1, 1, i);

    // mid-frame reset with ce=0
    do_edge(0, 0, 0);
    for (int i = 0; i < 20; i++) do_edge(1, 1, i);
    do_edge(0, 0, 77);
    for (int i = 100; i < 130; i++) do_edge(1, 1, i);

    // minimum line length
    h_size = 11'd2;
    do_edge(0, 0, 0);
    for (int i = 0; i < 20; i++) do_edge(1, 1, i);

    // h_size change in mid-line: line taps undefined for a line, so only tap0/col/line_end
    h_size = 11'd8;
    do_edge(0, 0, 0);
    for (int i = 0; i < 3; i++) do_edge(1, 1, i);
    h_size = 11'd4;
    chk_lines = 1'b0;
    for (int i = 3; i < 23; i++) do_edge(1, 1, i);

    // maximum line length
    h_size = 11'd1024;
    do_edge(0, 0, 0);
    for (int i = 0; i < 2100; i++) do_edge(1, 1, i);

    ce = 1'b0;
    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
